// File: rtl/qmaxtable_pkg.sv
// Shared q-learning table constants and types.
// Used by the Q-max table and its RAM banks.
package qmaxtable_pkg;

  localparam int QMAX_ADDR_WIDTH = 16;
  localparam int QMAX_DATA_WIDTH = 32;
  localparam int QMAX_DEPTH      = 65536;
  localparam int QMAX_NUM_RD     = 2;

  localparam logic [31:0] QMAX_INIT_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } qmax_state_e;

  // Which registered source drives a read port's o_data slice.
  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_FWD  = 2'd1,
    SRC_INIT = 2'd2,
    SRC_ZERO = 2'd3
  } qmax_src_e;

endpackage

// File: rtl/qmaxtable_mp_bank.sv
// qmax_bank: one 1W1R synchronous-read RAM.
// Read-first on a same-address collision.
module qmax_bank
  import qmaxtable_pkg::*;
#(
  parameter int IW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [IW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic          i_re,
  input  logic [IW-1:0] i_ra,
  output logic [DW-1:0] o_rd
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_wa] <= i_wd;
    if (i_re) rd_q <= mem_q[i_ra];
  end

  assign o_rd = rd_q;

endmodule

// File: rtl/qmaxtable_mp.sv
// Multi-read-port Q-max table with clear sequencer,
// write forwarding and out-of-range read handling.
module qmaxtable_mp
  import qmaxtable_pkg::*;
#(
  parameter int ADDR_WIDTH = QMAX_ADDR_WIDTH,
  parameter int DATA_WIDTH = QMAX_DATA_WIDTH,
  parameter int DEPTH      = QMAX_DEPTH,
  parameter int NUM_RD     = QMAX_NUM_RD,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE =
    DATA_WIDTH'(QMAX_INIT_DEFAULT),
  parameter int BYPASS     = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clear,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_addr_r,
  input  logic [NUM_RD-1:0]            i_read_en,
  input  logic [ADDR_WIDTH-1:0]        i_addr_w,
  input  logic                         i_write_en,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_data,
  output logic [NUM_RD-1:0]            o_valid,
  output logic                         o_busy
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_A =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH-1);

  qmax_state_e   state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + IW'(1);
      end
    end
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy = busy_q;

  logic            clearing;
  logic            rd_ok;
  logic            wr_ok;
  logic            bank_we;
  logic [IW-1:0]   bank_wa;
  logic [DATA_WIDTH-1:0] bank_wd;

  // A clear or reset request in a READY cycle wins over traffic.
  assign clearing = (state_q == ST_CLEAR);
  assign rd_ok    = !clearing && !i_clear && !i_rst;
  assign wr_ok    = rd_ok && i_write_en &&
                    ({1'b0, i_addr_w} < DEPTH_A);

  assign bank_we = clearing || wr_ok;
  assign bank_wa = clearing ? cnt_q : i_addr_w[IW-1:0];
  assign bank_wd = clearing ? INIT_VALUE : i_data;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_rng;
    logic                  rd;
    logic                  fwd;
    qmax_src_e             src_q, src_d;
    logic [DATA_WIDTH-1:0] fwd_q, fwd_d;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] dout;
    logic                  vld_q, vld_d;

    assign addr   = i_addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign in_rng = ({1'b0, addr} < DEPTH_A);
    assign rd     = rd_ok && i_read_en[k];
    assign fwd    = (BYPASS != 0) && wr_ok &&
                    (i_addr_w == addr);

    always_comb begin
      src_d = src_q;
      fwd_d = fwd_q;
      vld_d = rd;
      if (rd) begin
        if (!in_rng) begin
          src_d = SRC_INIT;
        end else if (fwd) begin
          src_d = SRC_FWD;
          fwd_d = i_data;
        end else begin
          src_d = SRC_RAM;
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        src_q <= SRC_ZERO;
        vld_q <= 1'b0;
      end else begin
        src_q <= src_d;
        vld_q <= vld_d;
      end
      fwd_q <= fwd_d;
    end

    qmax_bank #(
      .IW    (IW),
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .i_clk (i_clk),
      .i_we  (bank_we),
      .i_wa  (bank_wa),
      .i_wd  (bank_wd),
      .i_re  (rd && in_rng),
      .i_ra  (addr[IW-1:0]),
      .o_rd  (ram_q)
    );

    always_comb begin
      dout = '0;
      unique case (src_q)
        SRC_RAM:  dout = ram_q;
        SRC_FWD:  dout = fwd_q;
        SRC_INIT: dout = INIT_VALUE;
        default:  dout = '0;
      endcase
    end

    assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = dout;
    assign o_valid[k] = vld_q;
  end

endmodule

// File: tb/tb_qmaxtable_mp.sv
// Bench for qmaxtable_mp: a forwarding 16-entry instance and a
// non-forwarding instance with 5-bit addresses over 16 entries.
module tb_qmaxtable_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, we;
  logic [1:0]  re;
  logic [4:0]  a0, a1, aw;
  logic [31:0] d;

  logic [63:0] da, db;
  logic [1:0]  va, vb;
  logic        ba, bb;

  qmaxtable_mp #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16),
    .NUM_RD(2), .INIT_VALUE(32'h0), .BYPASS(1)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_addr_r({a1[3:0], a0[3:0]}), .i_read_en(re),
    .i_addr_w(aw[3:0]), .i_write_en(we), .i_data(d),
    .o_data(da), .o_valid(va), .o_busy(ba)
  );

  qmaxtable_mp #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16),
    .NUM_RD(2), .INIT_VALUE(32'h0), .BYPASS(0)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_clear(clr),
    .i_addr_r({a1, a0}), .i_read_en(re),
    .i_addr_w(aw), .i_write_en(we), .i_data(d),
    .o_data(db), .o_valid(vb), .o_busy(bb)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference model: table contents, remaining clear cycles,
  // expected read results per (instance, port).
  logic [31:0] mem_m [2][16];
  int          left;
  logic        busy_exp;
  logic [31:0] hold_exp [4];
  logic [31:0] exp_q [4][$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, ex);
    end
  endtask

  task automatic model_edge();
    if (rst || clr) begin
      left = 16;
      for (int n = 0; n < 2; n++)
        for (int i = 0; i < 16; i++) mem_m[n][i] = 32'h0;
      if (rst)
        for (int i = 0; i < 4; i++) hold_exp[i] = 32'h0;
    end else if (left > 0) begin
      left--;
    end else begin
      for (int n = 0; n < 2; n++) begin
        int w;
        w = (n == 0) ? int'(aw[3:0]) : int'(aw);
        for (int k = 0; k < 2; k++) begin
          int r;
          logic [31:0] v;
          r = (k == 0) ? int'(a0) : int'(a1);
          if (n == 0) r = r % 16;
          if (re[k]) begin
            if (r >= 16) v = 32'h0;
            else if (n == 0 && we && w == r) v = d;
            else v = mem_m[n][r];
            exp_q[n*2+k].push_back(v);
            hold_exp[n*2+k] = v;
          end
        end
        if (we && w < 16) mem_m[n][w] = d;
      end
    end
    busy_exp = (left > 0);
  endtask

  task automatic cyc(input logic r, input logic c,
                     input logic [1:0] e,
                     input logic [4:0] x0, input logic [4:0] x1,
                     input logic w, input logic [4:0] wa,
                     input logic [31:0] wd);
    rst = r; clr = c; re = e;
    a0 = x0; a1 = x1; we = w; aw = wa; d = wd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 32'h0);
  endtask

  task automatic junk_until_ready();
    while (left > 0)
      cyc(0, 0, 2'($urandom), 5'($urandom), 5'($urandom),
          1'b1, 5'($urandom), 32'hDEAD_BEEF);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++)
      cyc(0, 0, 2'b11, 5'(i), 5'(15 - i), 0, 5'd0, 32'h0);
  endtask

  // Monitor: pops the scoreboard whenever a port shows valid.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int n = 0; n < 2; n++) begin
          chk($sformatf("busy_i%0d", n),
              {31'b0, (n == 0) ? ba : bb}, {31'b0, busy_exp});
          for (int k = 0; k < 2; k++) begin
            int id;
            logic v;
            logic [31:0] g;
            logic [31:0] ex;
            id = n * 2 + k;
            v  = (n == 0) ? va[k] : vb[k];
            g  = (n == 0) ? da[k*32 +: 32] : db[k*32 +: 32];
            if (v) begin
              if (exp_q[id].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid_i%0d_p%0d got=1 exp=0", n, k);
              end else begin
                ex = exp_q[id].pop_front();
                chk($sformatf("rdata_i%0d_p%0d", n, k), g, ex);
              end
            end else begin
              chk($sformatf("hold_i%0d_p%0d", n, k), g,
                  hold_exp[id]);
            end
          end
        end
      end
    end
  end

  initial begin
    left = 16;
    busy_exp = 1'b1;
    for (int i = 0; i < 4; i++) hold_exp[i] = 32'h0;
    rst = 1'b1; clr = 1'b0; re = '0; we = 1'b0;
    a0 = '0; a1 = '0; aw = '0; d = '0;

    cyc(1, 0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 32'h0);
    mon_en = 1'b1;
    cyc(1, 0, 2'b11, 5'd1, 5'd2, 1, 5'd1, 32'h1234);
    junk_until_ready();
    read_all();

    cyc(0, 0, 2'b00, 5'd0, 5'd0, 1, 5'd5, 32'h3F80_0000);
    cyc(0, 0, 2'b11, 5'd5, 5'd6, 0, 5'd0, 32'h0);
    cyc(0, 0, 2'b11, 5'd3, 5'd5, 1, 5'd3, 32'h4000_0000);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 1, 5'd20, 32'h77);
    cyc(0, 0, 2'b11, 5'd20, 5'd4, 0, 5'd0, 32'h0);
    cyc(0, 0, 2'b11, 5'd31, 5'd3, 0, 5'd0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 59) == 0,
          2'($urandom),
          5'($urandom), 5'($urandom),
          1'($urandom), 5'($urandom), $urandom);
    end
    junk_until_ready();

    for (int i = 0; i < 16; i++)
      cyc(0, 0, 2'b00, 5'd0, 5'd0, 1, 5'(i), 32'hA000_0000 | i);
    read_all();
    cyc(0, 1, 2'b11, 5'd1, 5'd2, 0, 5'd0, 32'h0);
    junk_until_ready();
    read_all();

    for (int i = 0; i < 16; i++)
      cyc(0, 0, 2'b00, 5'd0, 5'd0, 1, 5'(i), 32'hB000_0000 | i);
    cyc(0, 1, 2'b00, 5'd0, 5'd0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 8; i++) idle();
    cyc(1, 0, 2'b11, 5'd0, 5'd1, 1, 5'd0, 32'h5);
    junk_until_ready();
    read_all();

    cyc(0, 0, 2'b00, 5'd0, 5'd0, 1, 5'd2, 32'h55);
    cyc(0, 1, 2'b00, 5'd0, 5'd0, 1, 5'd2, 32'h1);
    junk_until_ready();
    cyc(0, 0, 2'b11, 5'd2, 5'd2, 0, 5'd0, 32'h0);
    idle();
    idle();
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("pending_q%0d", i),
          32'(exp_q[i].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qmaxtable_mp.md
QMAXTABLE_MP -- requirements
Module: qmaxtable_mp

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, entry width in bits (IEEE-754 single Q-max value).
REQ-003 Parameter DEPTH, default 65536, number of entries, 2 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter NUM_RD, default 2, number of independent read ports, 1..8.
REQ-005 Parameter INIT_VALUE, default 32'h0000_0000, value written to every entry by the clear sequence.
REQ-006 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled, 0 = disabled.
REQ-007 i_clk  input  1  single clock; all logic on the rising edge.
REQ-008 i_rst  input  1  synchronous, active-high reset.
REQ-009 i_clear  input  1  single-cycle pulse requesting re-initialisation of all entries without reset.
REQ-010 i_addr_r  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 i_read_en  input  NUM_RD  per-port read enable.
REQ-012 i_addr_w  input  ADDR_WIDTH  write address.
REQ-013 i_write_en  input  1  write enable.
REQ-014 i_data  input  DATA_WIDTH  write data.
REQ-015 o_data  output  NUM_RD*DATA_WIDTH  packed registered read data, same packing as i_addr_r.
REQ-016 o_valid  output  NUM_RD  per-port flag: o_data slice holds the result of a read issued the previous cycle.
REQ-017 o_busy  output  1  high while the clear sequence runs; writes and reads are ignored.

Function
REQ-018 FSM states: CLEAR and READY; i_rst or an i_clear pulse enters CLEAR with clear counter = 0.
REQ-019 In CLEAR, each cycle writes INIT_VALUE to entry [counter] and increments the counter; after writing entry DEPTH-1, go to READY on the next edge (exactly DEPTH cycles in CLEAR).
REQ-020 o_busy is 1 in every CLEAR cycle and 0 in READY.
REQ-021 In CLEAR, i_write_en and i_read_en are ignored, o_valid is 0 for all ports, and o_data holds its value.
REQ-022 i_clear asserted while in CLEAR restarts the sequence at counter 0.
REQ-023 In READY with i_write_en=1, entry [i_addr_w] takes i_data at the clock edge.
REQ-024 In READY with i_read_en[k]=1, o_data slice k takes entry [addr_k] at the next edge and o_valid[k]=1 (latency 1); otherwise o_valid[k]=0 and slice k holds.
REQ-025 With BYPASS=1, a read and a write to the same address in the same READY cycle return i_data; with BYPASS=0 they return the pre-write contents.
REQ-026 Read ports are fully independent; any ports may read the same or different addresses in the same cycle.
REQ-027 Addresses >= DEPTH are out of range: writes are dropped, and reads return INIT_VALUE with o_valid=1.
REQ-028 An i_clear and an i_write_en in the same READY cycle: the clear wins and the write is dropped.

Reset
REQ-029 On i_rst: o_data = 0, o_valid = 0, o_busy = 1 on the following cycle, FSM = CLEAR, counter = 0.
REQ-030 i_rst asserted mid-clear restarts clearing from entry 0; reset while READY discards any read in flight (o_valid = 0 next cycle).
REQ-031 Memory contents are not reset directly; only the clear sequence initialises them.

Structure
REQ-032 The FSM state encoding (CLEAR, READY) and the default INIT_VALUE belong in the shared q-learning package, alongside existing table constants.
REQ-033 One sub-module, qmax_bank, holds a single 1W1R synchronous-read RAM (BRAM-inferable).
REQ-034 qmax_bank is instantiated NUM_RD times; every instance receives the identical write stream, including clear writes.
REQ-035 Forwarding and out-of-range logic sit in the top level, outside qmax_bank, so the RAM still infers.

Verification (DEPTH=16, ADDR_WIDTH=4, NUM_RD=2, INIT_VALUE=32'h0)
REQ-036 Reset pulse -> o_busy high exactly 16 cycles; then reads of all 16 addresses return 32'h0 with o_valid=1 one cycle later.
REQ-037 Write 32'h3F80_0000 to addr 5, next cycle read port0 addr 5 and port1 addr 6 -> 32'h3F80_0000 and 32'h0, both valid.
REQ-038 Same-cycle write 32'h4000_0000 to addr 3 and read addr 3: BYPASS=1 -> 32'h4000_0000; BYPASS=0 -> old value 32'h0.
REQ-039 Fill addr 0..15 with nonzero data, pulse i_clear, issue reads and writes during busy -> no o_valid, writes lost, all entries read 32'h0 afterwards.
REQ-040 Assert i_rst at clear cycle 8 -> o_busy stays high 16 further cycles, and entries 0..15 read 32'h0.
REQ-041 Same-cycle i_clear and write 32'h1 to addr 2 -> after clear, addr 2 reads 32'h0.
